blob_centroid: RTL and testbench

- Downstream of the colour-filter / HSV processing stage. Consumes that stage's per-pixel match mask together with its row/col coordinates and the VGA vertical sync.
- Accumulates the match count and the sums of matched-pixel x and y over each frame.
- At each frame boundary it computes the centroid (mean col, mean row) with a sequential restoring divider. Results go to the overlay/crosshair logic and the HEX/LED debug display.

---
 rtl/centroid_pkg.sv | 20 ++
 rtl/seq_divider.sv | 67 ++++++
 rtl/blob_centroid.sv | 157 +++++++++++++++
 tb/tb_blob_centroid.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared widths, frame limits and controller states for the blob centroid block.
package centroid_pkg;

    localparam int COORD_W = 13;
    localparam int OUT_W   = 10;
    localparam int CNT_W   = 19;
    localparam int SUM_W   = 28;

    localparam logic [COORD_W-1:0] H_ACT     = 13'd640;
    localparam logic [COORD_W-1:0] V_ACT     = 13'd480;
    localparam logic [CNT_W-1:0]   MIN_COUNT = 19'd64;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start cycle already
// performs the first step, so the quotient is ready and done pulses N cycles after start.
module seq_divider #(
    parameter int N  = centroid_pkg::SUM_W,
    parameter int QW = centroid_pkg::OUT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] STEPS_LEFT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_STEP   = {{(CW-1){1'b0}}, 1'b1};

    logic [N-1:0]  rem_r, quo_r, dsr_r;
    logic [CW-1:0] cnt_r;
    logic          done_r;

    logic [N-1:0]  rem_in_s, quo_in_s, dsr_in_s, rem_next_s, quo_next_s;
    logic [N:0]    shifted_s, trial_s;
    logic          bit_s;

    // One restoring step; a borrow out of the trial subtraction means the bit is 0.
    always_comb begin
        rem_in_s   = start ? {N{1'b0}} : rem_r;
        quo_in_s   = start ? dividend  : quo_r;
        dsr_in_s   = start ? divisor   : dsr_r;
        shifted_s  = {rem_in_s, quo_in_s[N-1]};
        trial_s    = shifted_s - {1'b0, dsr_in_s};
        bit_s      = ~trial_s[N];
        rem_next_s = bit_s ? trial_s[N-1:0] : shifted_s[N-1:0];
        quo_next_s = {quo_in_s[N-2:0], bit_s};
    end

    // Iteration registers and step counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_r  <= {N{1'b0}};
            quo_r  <= {N{1'b0}};
            dsr_r  <= {N{1'b0}};
            cnt_r  <= {CW{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rem_r <= rem_next_s;
                quo_r <= quo_next_s;
                dsr_r <= divisor;
                cnt_r <= STEPS_LEFT;
            end else if (cnt_r != {CW{1'b0}}) begin
                rem_r  <= rem_next_s;
                quo_r  <= quo_next_s;
                cnt_r  <= cnt_r - ONE_STEP;
                done_r <= (cnt_r == ONE_STEP);
            end
        end
    end

    assign done     = done_r;
    assign quotient = quo_r[QW-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Per-frame match count and coordinate sums; at each vsync falling edge the centroid
// is computed by one shared sequential divider (x first, then y).
module blob_centroid
    import centroid_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vs,
    input  logic               pix_valid,
    input  logic               mask,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    output logic [OUT_W-1:0]   cx,
    output logic [OUT_W-1:0]   cy,
    output logic [CNT_W-1:0]   blob_count,
    output logic               found,
    output logic               result_valid,
    output logic               busy,
    output logic               frame_drop
);

    state_t             state_r, state_next_s;
    logic               vs_d_r;
    logic [CNT_W-1:0]   cnt_acc_r, cnt_s_r, cnt_inc_s;
    logic [SUM_W-1:0]   sx_acc_r, sy_acc_r, sy_s_r, sx_inc_s, sy_inc_s;
    logic [OUT_W-1:0]   qx_r, cx_r, cy_r;
    logic [CNT_W-1:0]   blob_count_r;
    logic               found_r, result_valid_r, busy_r, frame_drop_r;
    logic               hit_s, fe_s, snap_found_s;
    logic               div_start_s, div_done_s;
    logic [SUM_W-1:0]   div_dividend_s, div_divisor_s;
    logic [OUT_W-1:0]   div_quo_s;

    assign hit_s        = pix_valid & mask & (col < H_ACT) & (row < V_ACT);
    assign fe_s         = vs_d_r & ~vs;
    assign cnt_inc_s    = (hit_s && (cnt_acc_r != {CNT_W{1'b1}})) ? cnt_acc_r + 19'd1 : cnt_acc_r;
    assign sx_inc_s     = hit_s ? sx_acc_r + {{(SUM_W-COORD_W){1'b0}}, col} : sx_acc_r;
    assign sy_inc_s     = hit_s ? sy_acc_r + {{(SUM_W-COORD_W){1'b0}}, row} : sy_acc_r;
    assign snap_found_s = (cnt_inc_s >= MIN_COUNT);

    seq_divider #(.N(SUM_W), .QW(OUT_W)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .done     (div_done_s),
        .quotient (div_quo_s)
    );

    // Next state and divider launch; x starts straight from the live snapshot.
    always_comb begin
        state_next_s   = state_r;
        div_start_s    = 1'b0;
        div_dividend_s = sx_inc_s;
        div_divisor_s  = {{(SUM_W-CNT_W){1'b0}}, cnt_inc_s};
        case (state_r)
            ACCUM: begin
                if (fe_s) begin
                    div_start_s  = snap_found_s;
                    state_next_s = snap_found_s ? DIV_X : DONE;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            DIV_X: begin
                if (div_done_s) begin
                    div_start_s    = 1'b1;
                    div_dividend_s = sy_s_r;
                    div_divisor_s  = {{(SUM_W-CNT_W){1'b0}}, cnt_s_r};
                    state_next_s   = DIV_Y;
                end else begin
                    state_next_s = DIV_X;
                end
            end
            DIV_Y: begin
                if (div_done_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DIV_Y;
                end
            end
            DONE:    state_next_s = ACCUM;
            default: state_next_s = ACCUM;
        endcase
    end

    // State, edge detector, accumulators and frame snapshot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ACCUM;
            vs_d_r       <= 1'b1;
            cnt_acc_r    <= {CNT_W{1'b0}};
            sx_acc_r     <= {SUM_W{1'b0}};
            sy_acc_r     <= {SUM_W{1'b0}};
            cnt_s_r      <= {CNT_W{1'b0}};
            sy_s_r       <= {SUM_W{1'b0}};
            frame_drop_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            vs_d_r  <= vs;
            if (fe_s && (state_r == ACCUM)) begin
                cnt_s_r   <= cnt_inc_s;
                sy_s_r    <= sy_inc_s;
                cnt_acc_r <= {CNT_W{1'b0}};
                sx_acc_r  <= {SUM_W{1'b0}};
                sy_acc_r  <= {SUM_W{1'b0}};
            end else begin
                cnt_acc_r <= cnt_inc_s;
                sx_acc_r  <= sx_inc_s;
                sy_acc_r  <= sy_inc_s;
            end
            if (fe_s && (state_r != ACCUM)) begin
                frame_drop_r <= 1'b1;
            end
        end
    end

    // Result registers, loaded on the edge that enters DONE so they are valid during it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            qx_r           <= {OUT_W{1'b0}};
            cx_r           <= {OUT_W{1'b0}};
            cy_r           <= {OUT_W{1'b0}};
            blob_count_r   <= {CNT_W{1'b0}};
            found_r        <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            busy_r         <= (state_next_s == DIV_X) || (state_next_s == DIV_Y);
            result_valid_r <= 1'b0;
            if ((state_r == DIV_X) && div_done_s) begin
                qx_r <= div_quo_s;
            end
            if ((state_r == ACCUM) && fe_s && !snap_found_s) begin
                blob_count_r   <= cnt_inc_s;
                found_r        <= 1'b0;
                result_valid_r <= 1'b1;
            end else if ((state_r == DIV_Y) && div_done_s) begin
                blob_count_r   <= cnt_s_r;
                found_r        <= 1'b1;
                cx_r           <= qx_r;
                cy_r           <= div_quo_s;
                result_valid_r <= 1'b1;
            end
        end
    end

    assign cx           = cx_r;
    assign cy           = cy_r;
    assign blob_count   = blob_count_r;
    assign found        = found_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign frame_drop   = frame_drop_r;

endmodule

// File: tb/tb_blob_centroid.sv
// Randomized scoreboard bench for blob_centroid: a frame-level reference model predicts
// each result (values and arrival cycle); a monitor pops and compares on result_valid.
module tb_blob_centroid;
    import centroid_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vs = 1'b1;
    logic        pix_valid = 1'b0;
    logic        mask = 1'b0;
    logic [12:0] row = 13'd0;
    logic [12:0] col = 13'd0;
    logic [9:0]  cx, cy;
    logic [18:0] blob_count;
    logic        found, result_valid, busy, frame_drop;

    blob_centroid dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vs           (vs),
        .pix_valid    (pix_valid),
        .mask         (mask),
        .row          (row),
        .col          (col),
        .cx           (cx),
        .cy           (cy),
        .blob_count   (blob_count),
        .found        (found),
        .result_valid (result_valid),
        .busy         (busy),
        .frame_drop   (frame_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic [18:0] cnt;
        logic        found;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: plain per-frame totals.
    longint     m_cnt = 0, m_sx = 0, m_sy = 0;
    int         m_ready = 0;
    bit         m_prev_vs = 1'b1;
    bit         m_drop = 1'b0;
    logic [9:0] m_cx = 10'd0, m_cy = 10'd0;
    int         busy_lo = 1, busy_hi = 0;
    bit         mon_on = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle and advance the model with the same inputs.
    task automatic drive(input bit rst, input bit pv, input bit m, input bit v,
                         input logic [12:0] r, input logic [12:0] c);
        int   t;
        bit   hit, fe;
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = !rst; pix_valid = pv; mask = m; vs = v; row = r; col = c;
        t = cyc;
        if (rst) begin
            sb_q.delete();
            m_cnt = 0; m_sx = 0; m_sy = 0;
            m_ready = 0; m_drop = 1'b0; m_prev_vs = 1'b1;
            m_cx = 10'd0; m_cy = 10'd0;
            if (busy_hi > t) busy_hi = t;
        end else begin
            hit = pv && m && (c < 13'd640) && (r < 13'd480);
            fe  = m_prev_vs && !v;
            if (hit) begin
                m_cnt++; m_sx += c; m_sy += r;
            end
            if (fe && t >= m_ready) begin
                e.found = (m_cnt >= 64);
                e.cnt   = 19'(m_cnt);
                if (e.found) begin
                    m_cx = 10'(m_sx / m_cnt);
                    m_cy = 10'(m_sy / m_cnt);
                    busy_lo = t + 1;
                    busy_hi = t + 2 * SUM_W;
                end
                e.cx = m_cx;
                e.cy = m_cy;
                e.at = e.found ? t + 2 * SUM_W + 1 : t + 1;
                m_ready = e.at + 1;
                sb_q.push_back(e);
                m_cnt = 0; m_sx = 0; m_sy = 0;
            end else if (fe) begin
                m_drop = 1'b1;
            end
            m_prev_vs = v;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b1, 13'd0, 13'd0);
    endtask

    task automatic hits(input int n, input logic [12:0] r, input logic [12:0] c);
        repeat (n) drive(1'b0, 1'b1, 1'b1, 1'b1, r, c);
    endtask

    task automatic rnd_pixel(input bit v);
        logic [12:0] r, c;
        c = ($urandom_range(0, 9) == 0) ? 13'(13'h1FFF - $urandom_range(0, 7)) : 13'($urandom_range(0, 700));
        r = ($urandom_range(0, 9) == 0) ? 13'(13'h1FFF - $urandom_range(0, 7)) : 13'($urandom_range(0, 520));
        drive(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, v, r, c);
    endtask

    task automatic fe_pulse(input bit noisy);
        repeat (3) begin
            if (noisy) rnd_pixel(1'b0);
            else drive(1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 13'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_cx"}, cx, 0);
        chk({tag, "_cy"}, cy, 0);
        chk({tag, "_blob_count"}, blob_count, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_drop"}, frame_drop, 0);
    endtask

    // Monitor: busy window every cycle, full result compare on each result_valid.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            if (result_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result_cycle", cyc, mon_e.at);
                    chk("blob_count", blob_count, mon_e.cnt);
                    chk("found", found, mon_e.found);
                    chk("cx", cx, mon_e.cx);
                    chk("cy", cy, mon_e.cy);
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 13'd0, 13'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 13'd0, 13'd0);
        mon_on = 1'b1;
        idle(1);
        check_zero_outputs("reset");
        idle(4);

        // 64 identical hits -> centroid (100,50), 57-cycle latency
        hits(64, 13'd50, 13'd100);
        fe_pulse(1'b0);
        idle(70);

        // 63 hits -> below threshold, cx/cy hold, latency 1
        hits(63, 13'd200, 13'd300);
        fe_pulse(1'b0);
        idle(10);

        // only out-of-range or unqualified pixels -> count 0
        hits(20, 13'd10, 13'h1FFC);
        hits(20, 13'd480, 13'd5);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b1, 13'd10, 13'd10);
        repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b1, 13'd10, 13'd10);
        fe_pulse(1'b0);
        idle(10);

        // random frames, hits also allowed during the vsync pulse
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(20, 400)) rnd_pixel(1'b1);
            fe_pulse(1'b1);
            idle(70);
        end

        // second edge 10 cycles after the first is dropped and frames merge
        hits(100, 13'd30, 13'd600);
        fe_pulse(1'b0);
        hits(7, 13'd1, 13'd2);
        fe_pulse(1'b0);
        hits(20, 13'd479, 13'd639);
        idle(60);
        hits(50, 13'd240, 13'd320);
        fe_pulse(1'b0);
        idle(70);
        @(negedge clk);
        chk("frame_drop_sticky", frame_drop, m_drop);

        // large frame biased to the bottom-right corner
        repeat (3000) drive(1'b0, 1'b1, $urandom_range(0, 3) != 0, 1'b1,
                            13'($urandom_range(400, 481)), 13'($urandom_range(560, 641)));
        fe_pulse(1'b0);
        idle(70);

        // reset while dividing y: no result, everything back to zero
        hits(80, 13'd400, 13'd500);
        fe_pulse(1'b0);
        idle(35);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 13'd0, 13'd0);
        idle(1);
        check_zero_outputs("abort");
        hits(70, 13'd123, 13'd456);
        fe_pulse(1'b0);
        idle(70);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
